// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: state encoding and default widths.
// No logic, so no latency.
// No handshakes here; ONE is the IEEE-754 1.0 constant used by MAC-side benches.
package conv_pkg;
    localparam int CONV_DIM_W  = 8;
    localparam int CONV_ADDR_W = 16;
    localparam logic [31:0] ONE = 32'h3f800000;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        DONE,
        ERR
    } conv_state_e;
endpackage

// File: rtl/conv_sequencer_if.sv
// Buffer-address and MAC handshake bundle between the sequencer and the datapath.
// Pure wiring, no latency.
// Terms move on mac_valid & mac_ready; results arrive on mac_result_valid and cannot be stalled.
interface conv_sequencer_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = CONV_ADDR_W
);
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] flt_addr;
    logic              mac_valid;
    logic              mac_ready;
    logic              mac_first;
    logic              mac_last;
    logic              mac_result_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_we;

    modport master (
        output in_addr, flt_addr, mac_valid, mac_first, mac_last, out_addr, out_we,
        input  mac_ready, mac_result_valid
    );

    modport slave (
        input  in_addr, flt_addr, mac_valid, mac_first, mac_last, out_addr, out_we,
        output mac_ready, mac_result_valid
    );
endinterface

// File: rtl/conv_out_fifo.sv
// Tracks output-buffer addresses of pixels whose MAC result is still in flight.
// Head is visible combinationally; push/pop take effect on the next edge.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module conv_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o   = (cnt_q == CW'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign do_pop   = pop_i & ~empty_o;
    assign do_push  = push_i & (~full_o | do_pop);
    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = cnt_q;

    // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/conv_sequencer.sv
// Walks output pixels (r,c) and filter taps (i,j), issuing buffer addresses and MAC first/last control.
// First term 2 cycles after start; done 1 cycle after the final result write.
// Terms hold while mac_ready is low; new pixels wait while OUT_Q results are outstanding.
// Optional CONV_PERF_CNT_EN adds cycle_count / stall_count outputs.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int DIM_W  = CONV_DIM_W,
    parameter int ADDR_W = CONV_ADDR_W,
    parameter int OUT_Q  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] input_size,
    input  logic [DIM_W-1:0] filter_size,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [DIM_W-1:0] output_size,
`ifdef CONV_PERF_CNT_EN
    output logic [31:0]      cycle_count,
    output logic [31:0]      stall_count,
`endif
    conv_sequencer_if.master mac_if
);
    localparam int CW = $clog2(OUT_Q + 1);
    localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    conv_state_e       state_q;
    logic              busy_q, done_q, error_q;
    logic [DIM_W-1:0]  osize_q, n_q, k_q, m_q;
    logic [DIM_W-1:0]  r_q, c_q, i_q, j_q, r_d, c_d, i_d, j_d;
    // row_base = r*N, pix_base = r*N + c, win_row = pix_base + i*N
    logic [ADDR_W-1:0] row_base_q, pix_base_q, win_row_q, row_base_d, pix_base_d, win_row_d;
    logic [ADDR_W-1:0] in_addr_q, flt_addr_q, in_addr_d, flt_addr_d, out_cnt_q;
    logic              mac_valid_q, mac_first_q, mac_last_q, mac_first_d, mac_last_d;
    logic              job_end;
    logic [ADDR_W-1:0] n_ext;
    logic [DIM_W-1:0]  k_last, m_last;
    logic              xfer, push, pop;
    logic [ADDR_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt, occ_d;
    logic              occ_full_d;

    assign n_ext  = ADDR_W'(n_q);
    assign k_last = k_q - DIM_ONE;
    assign m_last = m_q - DIM_ONE;
    assign xfer   = mac_valid_q & mac_if.mac_ready;
    assign push   = xfer & mac_last_q;
    assign pop    = mac_if.mac_result_valid & ~fifo_empty & ((state_q == RUN) | (state_q == DRAIN));
    assign occ_d  = fifo_cnt + CW'(push) - CW'(pop);
    assign occ_full_d = (occ_d == CW'(OUT_Q));

    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign output_size        = osize_q;
    assign mac_if.in_addr     = in_addr_q;
    assign mac_if.flt_addr    = flt_addr_q;
    assign mac_if.mac_valid   = mac_valid_q;
    assign mac_if.mac_first   = mac_first_q;
    assign mac_if.mac_last    = mac_last_q;
    assign mac_if.out_we      = pop;
    assign mac_if.out_addr    = fifo_empty ? '0 : fifo_head;

    conv_out_fifo #(.DEPTH(OUT_Q), .W(ADDR_W)) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (out_cnt_q),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    // Next loop position and addresses for the term after the current one (j innermost, then i, c, r).
    always_comb begin
        j_d = j_q; i_d = i_q; c_d = c_q; r_d = r_q;
        row_base_d = row_base_q; pix_base_d = pix_base_q; win_row_d = win_row_q;
        in_addr_d  = in_addr_q + ADDR_ONE;
        flt_addr_d = flt_addr_q + ADDR_ONE;
        job_end    = 1'b0;
        if (j_q != k_last) begin
            j_d = j_q + DIM_ONE;
        end else begin
            j_d = '0;
            if (i_q != k_last) begin
                i_d       = i_q + DIM_ONE;
                win_row_d = win_row_q + n_ext;
                in_addr_d = win_row_q + n_ext;
            end else begin
                i_d        = '0;
                flt_addr_d = '0;
                if (c_q != m_last) begin
                    c_d        = c_q + DIM_ONE;
                    pix_base_d = pix_base_q + ADDR_ONE;
                    win_row_d  = pix_base_q + ADDR_ONE;
                    in_addr_d  = pix_base_q + ADDR_ONE;
                end else begin
                    c_d = '0;
                    if (r_q != m_last) begin
                        r_d        = r_q + DIM_ONE;
                        row_base_d = row_base_q + n_ext;
                        pix_base_d = row_base_q + n_ext;
                        win_row_d  = row_base_q + n_ext;
                        in_addr_d  = row_base_q + n_ext;
                    end else begin
                        job_end = 1'b1;
                    end
                end
            end
        end
        mac_first_d = (i_d == '0) && (j_d == '0);
        mac_last_d  = (i_d == k_last) && (j_d == k_last);
    end

    // Job FSM with registered status and MAC control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
            osize_q <= '0; n_q <= '0; k_q <= '0; m_q <= '0;
            r_q <= '0; c_q <= '0; i_q <= '0; j_q <= '0;
            row_base_q <= '0; pix_base_q <= '0; win_row_q <= '0;
            in_addr_q <= '0; flt_addr_q <= '0; out_cnt_q <= '0;
            mac_valid_q <= 1'b0; mac_first_q <= 1'b0; mac_last_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    n_q     <= input_size;
                    k_q     <= filter_size;
                    busy_q  <= 1'b1;
                    state_q <= CHECK;
                end
                CHECK: if ((k_q == '0) || (n_q == '0) || (k_q > n_q)) begin
                    osize_q <= '0;
                    done_q  <= 1'b1;
                    error_q <= 1'b1;
                    state_q <= ERR;
                end else begin
                    m_q     <= n_q - k_q + DIM_ONE;
                    osize_q <= n_q - k_q + DIM_ONE;
                    r_q <= '0; c_q <= '0; i_q <= '0; j_q <= '0;
                    row_base_q <= '0; pix_base_q <= '0; win_row_q <= '0;
                    in_addr_q <= '0; flt_addr_q <= '0; out_cnt_q <= '0;
                    mac_valid_q <= 1'b1;
                    mac_first_q <= 1'b1;
                    mac_last_q  <= (k_q == DIM_ONE);
                    state_q     <= RUN;
                end
                RUN: begin
                    if (xfer) begin
                        if (mac_last_q) out_cnt_q <= out_cnt_q + ADDR_ONE;
                        if (job_end) begin
                            mac_valid_q <= 1'b0;
                            mac_first_q <= 1'b0;
                            mac_last_q  <= 1'b0;
                            state_q     <= DRAIN;
                        end else begin
                            r_q <= r_d; c_q <= c_d; i_q <= i_d; j_q <= j_d;
                            row_base_q <= row_base_d; pix_base_q <= pix_base_d; win_row_q <= win_row_d;
                            in_addr_q  <= in_addr_d;
                            flt_addr_q <= flt_addr_d;
                            mac_first_q <= mac_first_d;
                            mac_last_q  <= mac_last_d;
                            // A new pixel may not start while the tracking queue is full.
                            mac_valid_q <= !(mac_first_d && occ_full_d);
                        end
                    end else if (!mac_valid_q) begin
                        mac_valid_q <= !occ_full_d;
                    end
                end
                DRAIN: if (occ_d == '0) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE, ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CONV_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, stall_cnt_q;
    assign cycle_count = cycle_cnt_q;
    assign stall_count = stall_cnt_q;

    // Busy-cycle and MAC-backpressure counters, cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (busy_q) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (mac_valid_q && !mac_if.mac_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = fifo_full;
endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Control block for the convolution datapath. It walks the output-pixel and filter-window loops for an N×N input and a K×K filter.
- Per cycle it emits input-buffer and filter-buffer read addresses plus MAC control (first/last term).
- It writes each accumulated result to an output buffer at the correct address.
- It sits between the host-facing load logic (input/filter buffers already filled) and the 32-bit IEEE-754 multiply-accumulate unit. It replaces the implicit sequencing inside the monolithic ConvCalculator.

Parameters:
- DIM_W, 8, width of input_size / filter_size / output_size.
- ADDR_W, 16, width of all buffer addresses (must hold N*N-1).
- OUT_Q, 4, maximum outstanding output pixels (depth of output-address tracking).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- input_size  in  DIM_W  N, sampled with start
- filter_size  in  DIM_W  K, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle completion pulse
- error  out  1  single-cycle pulse, coincident with done, on illegal sizes
- output_size  out  DIM_W  N-K+1, latched at start; 0 on error
- in_addr  out  ADDR_W  input buffer read address, (r+i)*N + (c+j)
- flt_addr  out  ADDR_W  filter buffer read address, i*K + j
- mac_valid  out  1  term presented to MAC
- mac_ready  in  1  MAC accepts term; transfer = mac_valid & mac_ready
- mac_first  out  1  term is first of a pixel (MAC clears accumulator)
- mac_last  out  1  term is last of a pixel (MAC emits result later)
- mac_result_valid  in  1  MAC result available (any latency ≥1)
- out_addr  out  ADDR_W  output buffer write address, r*M + c
- out_we  out  1  write strobe = accepted mac_result_valid

Behaviour:
- Reset: state IDLE; busy, done, error, mac_valid, mac_first, mac_last, out_we = 0; addresses and output_size = 0; all counters = 0. Reset mid-job aborts immediately with no done pulse.
- States:
  - IDLE: start=1 → CHECK; latch N, K.
  - CHECK (1 cycle): if K==0, N==0 or K>N → ERR; else compute M=N-K+1, output_size=M → RUN.
  - RUN: mac_valid=1. On each transfer advance j, then i, then c, then r (innermost first, each wrapping at K,K,M,M). After the transfer with r=c=M-1, i=j=K-1 → DRAIN.
  - DRAIN: wait until result count == M*M → DONE.
  - DONE: done=1 one cycle, busy=0 next → IDLE.
  - ERR: done=1, error=1 one cycle → IDLE; no mac_valid ever asserted.
- mac_valid holds; address/first/last stay stable while mac_valid & ~mac_ready.
- mac_first = (i==0 & j==0); mac_last = (i==K-1 & j==K-1). K==1 → both high on every term.
- Output tracking:
  - Output addresses are pushed on the mac_last transfer and popped on mac_result_valid; out_addr = head.
  - If OUT_Q pixels are outstanding, mac_valid is held low on the next mac_first term until a pop.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- mac_result_valid with an empty queue or outside RUN/DRAIN is ignored (out_we=0).
- start while busy is ignored. Sizes changing mid-job have no effect.
- First mac_valid appears 2 cycles after the start cycle (IDLE→CHECK→RUN).
- Address arithmetic is unsigned, ADDR_W bits. Implement it incrementally (row base += N); no multipliers in the address path.

Optional Feature:
- CONV_PERF_CNT_EN defined: adds output cycle_count[31:0] and output stall_count[31:0].
  - Both are cleared on an accepted start.
  - cycle_count increments every busy cycle.
  - stall_count increments when mac_valid & ~mac_ready.
  - Both hold their value after done.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package conv_pkg: state encoding (IDLE, CHECK, RUN, DRAIN, DONE, ERR), DIM_W/ADDR_W defaults, and FP constant ONE = 32'h3f800000 for benches.
- Sub-module conv_out_fifo (OUT_Q × ADDR_W address FIFO, push/pop/full/empty) is natural.
- Loop counters stay inline.

Test Plan:
- N=8, K=6, mac_ready=1, result latency 4:
  - output_size=3; 324 transfers; first term in_addr=0, flt_addr=0.
  - Pixel (0,1) first in_addr=1; pixel (1,0) first in_addr=8; last term in_addr=63, flt_addr=35.
  - 9 out_we at addresses 0..8; done 1 cycle after the DRAIN exit.
- N=4, K=4 → output_size=1, 16 transfers, single out_we at address 0. N=4, K=1 → 16 pixels, mac_first=mac_last=1 every term.
- N=4, K=5 and N=4, K=0 → done & error pulse 2 cycles after start; mac_valid never high; output_size=0.
- N=8, K=6 with mac_ready random 50% → address sequence identical to scenario 1; stable values during stalls; with CONV_PERF_CNT_EN, stall_count equals the number of low-ready cycles while valid.
- Result latency 40 cycles, OUT_Q=4, N=8, K=2 (49 pixels) → mac_valid throttled at the 5th pixel until the first result; all 49 writes in order.
- rst asserted mid-RUN → all outputs 0 asynchronously, no done. Then start N=3, K=2 → normal 4-pixel job.
- start pulsed during busy → ignored, job count unchanged.
